// File: rtl/dsp_issue_ctrl.sv
// Command FIFO plus issue sequencer for a multi-latency DSP multiply stage.
// Mode changes drain the pipeline for three cycles before the new mode is issued.
module dsp_issue_ctrl #(
    parameter int N     = 9,
    parameter int M     = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic             in_mac,
    input  logic [1:0]       in_shift,
    input  logic [N-1:0]     in_aa,
    input  logic [M-1:0]     in_bb,
    input  logic [N+M-1:0]   in_cc,
    output logic             start,
    output logic [1:0]       mode,
    output logic             mac,
    output logic [1:0]       barrel_shifter,
    output logic [N-1:0]     aa,
    output logic [M-1:0]     bb,
    output logic [N+M-1:0]   cc,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [1:0]     mode;
        logic           mac;
        logic [1:0]     shift;
        logic [N-1:0]   aa;
        logic [M-1:0]   bb;
        logic [N+M-1:0] cc;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, HOLD} state_t;

    cmd_t           fifo_mem [DEPTH];
    cmd_t           in_cmd;
    cmd_t           head;
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           push, pop, load, free, err_next;

    state_t         state_reg, state_next;
    logic [1:0]     drain_cnt_reg, drain_cnt_next;
    logic [3:1]     start_dly_reg;

    logic           start_reg, mac_reg, err_reg;
    logic [1:0]     mode_reg, shift_reg;
    logic [N-1:0]   aa_reg;
    logic [M-1:0]   bb_reg;
    logic [N+M-1:0] cc_reg;

    assign in_cmd   = {in_mode, in_mac, in_shift, in_aa, in_bb, in_cc};
    assign head     = fifo_mem[rd_ptr_reg];
    assign in_ready = (count_reg != FULL_CNT);
    assign push     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= in_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // mode_reg doubles as the last issued mode and is held stable until the next load
    assign done = ((mode_reg == 2'b00) & start_reg)
                | ((mode_reg == 2'b01) & start_dly_reg[1])
                | ((mode_reg == 2'b10) & start_dly_reg[3]);

    // The done cycle behaves like IDLE so mode-00 commands can issue every cycle
    assign free = (state_reg == IDLE) | (((state_reg == ISSUE) | (state_reg == HOLD)) & done);

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        pop            = 1'b0;
        load           = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            DRAIN: begin
                drain_cnt_next = drain_cnt_reg + 2'd1;
                if (drain_cnt_reg == 2'd2) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE, HOLD: begin
                if (!done)
                    state_next = HOLD;
            end
            default: ;
        endcase
        if (free) begin
            state_next = IDLE;
            if (count_reg != '0) begin
                if (head.mode == 2'b11) begin
                    pop      = 1'b1;
                    err_next = 1'b1;
                end else if (head.mode != mode_reg) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 2'd0;
                end else begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= 2'd0;
            start_dly_reg <= '0;
            start_reg     <= 1'b0;
            err_reg       <= 1'b0;
            mode_reg      <= 2'b00;
            mac_reg       <= 1'b0;
            shift_reg     <= 2'b00;
            aa_reg        <= '0;
            bb_reg        <= '0;
            cc_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            start_dly_reg <= {start_dly_reg[2:1], start_reg};
            start_reg     <= load;
            err_reg       <= err_next;
            if (load) begin
                mode_reg  <= head.mode;
                mac_reg   <= head.mac;
                shift_reg <= head.shift;
                aa_reg    <= head.aa;
                bb_reg    <= head.bb;
                cc_reg    <= head.cc;
            end
        end
    end

    assign start          = start_reg;
    assign err            = err_reg;
    assign mode           = mode_reg;
    assign mac            = mac_reg;
    assign barrel_shifter = shift_reg;
    assign aa             = aa_reg;
    assign bb             = bb_reg;
    assign cc             = cc_reg;
    assign busy           = (count_reg != '0) | (state_reg != IDLE);

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Directed bench for dsp_issue_ctrl: per-scenario tasks check issue order, latency and reset.
module tb_dsp_issue_ctrl;
    localparam int N = 9;
    localparam int M = 9;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_mode;
    logic           in_mac;
    logic [1:0]     in_shift;
    logic [N-1:0]   in_aa;
    logic [M-1:0]   in_bb;
    logic [N+M-1:0] in_cc;
    logic           start;
    logic [1:0]     mode;
    logic           mac;
    logic [1:0]     barrel_shifter;
    logic [N-1:0]   aa;
    logic [M-1:0]   bb;
    logic [N+M-1:0] cc;
    logic           done;
    logic           err;
    logic           busy;

    dsp_issue_ctrl #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_mac(in_mac), .in_shift(in_shift),
        .in_aa(in_aa), .in_bb(in_bb), .in_cc(in_cc),
        .start(start), .mode(mode), .mac(mac), .barrel_shifter(barrel_shifter),
        .aa(aa), .bb(bb), .cc(cc),
        .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [1:0]     mode;
        logic [N-1:0]   aa;
        logic [M-1:0]   bb;
        logic [N+M-1:0] cc;
    } start_rec_t;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ready_low_cnt = 0;
    start_rec_t start_q[$];
    int         done_q[$];
    int         err_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (start) start_q.push_back('{cyc, mode, aa, bb, cc});
            if (done)  done_q.push_back(cyc);
            if (err)   err_q.push_back(cyc);
            if (!in_ready) ready_low_cnt <= ready_low_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        start_q.delete();
        done_q.delete();
        err_q.delete();
        ready_low_cnt = 0;
    endtask

    // Leaves in_valid high so consecutive calls push back-to-back
    task automatic push(input logic [1:0] m, input logic [N-1:0] a,
                        input logic [M-1:0] b, input logic [N+M-1:0] c);
        logic acc;
        in_valid = 1'b1;
        in_mode  = m;
        in_mac   = a[0];
        in_shift = a[2:1];
        in_aa    = a;
        in_bb    = b;
        in_cc    = c;
        for (int k = 0; k < 50; k++) begin
            acc = in_ready;
            tick;
            if (acc) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL push_timeout: aa=%0d not accepted within 50 cycles", a);
    endtask

    task automatic wait_idle;
        in_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!busy) return;
            tick;
        end
        n_cmp++; n_bad++;
        $display("FAIL idle_timeout: busy still %b after 200 cycles", busy);
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        in_mode  = 2'b00; in_mac = 1'b1; in_shift = 2'b11;
        in_aa = 9'h1FF; in_bb = 9'h1FF; in_cc = 18'h3FFFF;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++;
        if ({start, done, err, busy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: start/done/err/busy=%b expected 0000", {start, done, err, busy});
        end
        n_cmp++;
        if ({mode, mac, barrel_shifter, aa, bb, cc} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: mode=%b mac=%b sh=%b aa=%h bb=%h cc=%h expected all 0",
                     mode, mac, barrel_shifter, aa, bb, cc);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tick;
        n_cmp++;
        if ({in_ready, busy, start} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_release: in_ready/busy/start=%b expected 100", {in_ready, busy, start});
        end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_back_to_back;
        do_reset;
        for (int i = 0; i < 4; i++)
            push(2'b00, 9'd3, 9'h1FE, 18'(10 + i));
        wait_idle;
        n_cmp++;
        if (start_q.size() != 4 || done_q.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_count: starts=%0d dones=%0d expected 4/4", start_q.size(), done_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (start_q[i].cyc != start_q[0].cyc + i || done_q[i] != start_q[i].cyc ||
                    start_q[i].mode !== 2'b00 || start_q[i].aa !== 9'd3 ||
                    start_q[i].bb !== 9'h1FE || start_q[i].cc !== 18'(10 + i)) begin
                    n_bad++;
                    $display("FAIL b2b_issue%0d: cyc=%0d done=%0d mode=%b aa=%0d bb=%h cc=%0d expected cyc=%0d done=cyc mode=00 aa=3 bb=1fe cc=%0d",
                             i, start_q[i].cyc, done_q[i], start_q[i].mode, start_q[i].aa,
                             start_q[i].bb, start_q[i].cc, start_q[0].cyc + i, 10 + i);
                end
            end
        end
        n_cmp++;
        if (ready_low_cnt != 0) begin
            n_bad++;
            $display("FAIL b2b_in_ready: low for %0d cycles expected 0 (never full)", ready_low_cnt);
        end
        $display("test_back_to_back done: starts=%0d dones=%0d", start_q.size(), done_q.size());
    endtask

    task automatic test_mode10;
        logic found;
        do_reset;
        push(2'b10, 9'd100, 9'h1CE, 18'h00123);
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (start) begin found = 1'b1; break; end
            tick;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL m10_start_timeout: no start within 30 cycles");
        end else begin
            n_cmp++;
            if (mode !== 2'b10 || aa !== 9'd100 || bb !== 9'h1CE || cc !== 18'h00123 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL m10_issue: mode=%b aa=%0d bb=%h cc=%h done=%b expected 10/100/1ce/00123/0",
                         mode, aa, bb, cc, done);
            end
            for (int k = 1; k <= 3; k++) begin
                tick;
                n_cmp++;
                if (aa !== 9'd100 || bb !== 9'h1CE || mode !== 2'b10 || start !== 1'b0 ||
                    done !== (k == 3)) begin
                    n_bad++;
                    $display("FAIL m10_hold_t%0d: aa=%0d bb=%h mode=%b start=%b done=%b expected 100/1ce/10/0/%0d",
                             k, aa, bb, mode, start, done, (k == 3));
                end
            end
            tick;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL m10_after: busy=%b done=%b at t+4 expected 0/0", busy, done);
            end
        end
        $display("test_mode10 done: found=%b", found);
    endtask

    task automatic test_mode_change;
        do_reset;
        push(2'b01, 9'd5, 9'd6, 18'd7);
        push(2'b10, 9'd7, 9'd8, 18'd9);
        wait_idle;
        n_cmp++;
        if (start_q.size() != 2 || done_q.size() != 2) begin
            n_bad++;
            $display("FAIL mchg_count: starts=%0d dones=%0d expected 2/2", start_q.size(), done_q.size());
        end else begin
            n_cmp++;
            if (start_q[0].mode !== 2'b01 || start_q[0].aa !== 9'd5 ||
                start_q[1].mode !== 2'b10 || start_q[1].aa !== 9'd7) begin
                n_bad++;
                $display("FAIL mchg_order: modes=%b,%b aa=%0d,%0d expected 01,10 aa=5,7",
                         start_q[0].mode, start_q[1].mode, start_q[0].aa, start_q[1].aa);
            end
            n_cmp++;
            if (start_q[1].cyc - start_q[0].cyc != 5) begin
                n_bad++;
                $display("FAIL mchg_gap: start gap=%0d expected 5 (done+3 drain)", start_q[1].cyc - start_q[0].cyc);
            end
            n_cmp++;
            if (done_q[0] != start_q[0].cyc + 1 || done_q[1] != start_q[1].cyc + 3) begin
                n_bad++;
                $display("FAIL mchg_done: done at +%0d,+%0d expected +1,+3",
                         done_q[0] - start_q[0].cyc, done_q[1] - start_q[1].cyc);
            end
        end
        $display("test_mode_change done: starts=%0d dones=%0d", start_q.size(), done_q.size());
    endtask

    task automatic test_illegal;
        do_reset;
        push(2'b00, 9'd1, 9'd0, 18'd0);
        push(2'b11, 9'd2, 9'd0, 18'd0);
        push(2'b00, 9'd3, 9'd0, 18'd0);
        wait_idle;
        n_cmp++;
        if (err_q.size() != 1 || start_q.size() != 2) begin
            n_bad++;
            $display("FAIL illegal_count: errs=%0d starts=%0d expected 1/2", err_q.size(), start_q.size());
        end else begin
            n_cmp++;
            if (start_q[0].aa !== 9'd1 || start_q[1].aa !== 9'd3) begin
                n_bad++;
                $display("FAIL illegal_order: aa=%0d,%0d expected 1,3", start_q[0].aa, start_q[1].aa);
            end
            n_cmp++;
            if (!(err_q[0] > start_q[0].cyc && err_q[0] < start_q[1].cyc)) begin
                n_bad++;
                $display("FAIL illegal_err_cycle: err=%0d starts=%0d,%0d expected between",
                         err_q[0], start_q[0].cyc, start_q[1].cyc);
            end
        end
        $display("test_illegal done: errs=%0d starts=%0d", err_q.size(), start_q.size());
    endtask

    task automatic test_reset_hold;
        logic found;
        do_reset;
        push(2'b10, 9'd20, 9'd1, 18'd1);
        push(2'b10, 9'd21, 9'd1, 18'd1);
        push(2'b10, 9'd22, 9'd1, 18'd1);
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (start) begin found = 1'b1; break; end
            tick;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rsthold_start_timeout: no start within 30 cycles");
        end
        tick;
        rst = 1'b1;
        tick;
        n_cmp++;
        if ({start, done, err, busy, mode, mac, barrel_shifter, aa, bb, cc} !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rsthold_outputs: start=%b done=%b err=%b busy=%b mode=%b aa=%0d in_ready=%b expected all 0, in_ready=1",
                     start, done, err, busy, mode, aa, in_ready);
        end
        rst = 1'b0;
        start_q.delete();
        done_q.delete();
        for (int k = 0; k < 10; k++) tick;
        n_cmp++;
        if (start_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rsthold_abandon: starts=%0d dones=%0d busy=%b after reset expected 0/0/0",
                     start_q.size(), done_q.size(), busy);
        end
        $display("test_reset_hold done: starts_after=%0d dones_after=%0d", start_q.size(), done_q.size());
    endtask

    task automatic test_wrap;
        do_reset;
        for (int i = 0; i < 4; i++)
            push(2'b01, 9'(10 + i), 9'd2, 18'(100 + i));
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_full: in_ready=%b with 4 queued during drain expected 0", in_ready);
        end
        push(2'b01, 9'd14, 9'd2, 18'd104);
        wait_idle;
        n_cmp++;
        if (start_q.size() != 5 || done_q.size() != 5) begin
            n_bad++;
            $display("FAIL wrap_count: starts=%0d dones=%0d expected 5/5", start_q.size(), done_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (start_q[i].aa !== 9'(10 + i) || start_q[i].cc !== 18'(100 + i) ||
                    start_q[i].mode !== 2'b01 || done_q[i] != start_q[i].cyc + 1) begin
                    n_bad++;
                    $display("FAIL wrap_issue%0d: aa=%0d cc=%0d mode=%b done=+%0d expected aa=%0d cc=%0d mode=01 done=+1",
                             i, start_q[i].aa, start_q[i].cc, start_q[i].mode,
                             done_q[i] - start_q[i].cyc, 10 + i, 100 + i);
                end
            end
        end
        $display("test_wrap done: starts=%0d", start_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_mode = 2'b00; in_mac = 1'b0; in_shift = 2'b00;
        in_aa = '0; in_bb = '0; in_cc = '0;
        test_reset;
        test_back_to_back;
        test_mode10;
        test_mode_change;
        test_illegal;
        test_reset_hold;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
